fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side engine for the codebase's `fifo` / `fifo_asymmetric` buffers. It accepts a command to drain N words and issues `s_read_req` pulses against the FIFO's req/ready read port, absorbing the FIFO's one-cycle read-data latency. It re-presents the words as a valid/ready stream with `m_last` on the final word and a `done` pulse at the end. It sits between a buffer and a downstream compute or DMA consumer that needs back-pressure, which the raw FIFO read port cannot provide.

## Interface
- `DATA_WIDTH`, 64, word width; equals the attached FIFO's `s_read_data` width.
- `COUNT_WIDTH`, 16, width of the transfer-length field.
- `clk` in 1: sole clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_count` in COUNT_WIDTH: number of words to drain; 0 is legal.
- `s_read_req` out 1: FIFO read request.
- `s_read_ready` in 1: FIFO not empty.
- `s_read_data` in DATA_WIDTH: FIFO data, valid in the cycle after an accepted read.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream accepts.
- `m_data` out DATA_WIDTH: output word.
- `m_last` out 1: marks the final word of the command.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse at command completion.

## Operation
- **States: IDLE, READ, FLUSH.**
  - IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch `cmd_count` into `issue_left` and `out_left`.
    - If `cmd_count`==0: stay in IDLE and pulse `done` next cycle.
    - Otherwise go to READ.
  - READ: issue reads. When `issue_left` reaches 0, go to FLUSH.
  - FLUSH: wait for `out_left` to reach 0, then go to IDLE and pulse `done`.
- **Read accepted** means `s_read_req && s_read_ready` at a clock edge. Each accepted read decrements `issue_left` and sets the in-flight flag `inflight`. The word is captured from `s_read_data` at the next edge.
- **`s_read_req` is combinational.** It is 1 iff state==READ, `issue_left`≠0, `s_read_ready`=1 and `occ + inflight - pop < 2`.
  - `occ` is the skid-buffer occupancy (0..2).
  - `pop` = `m_valid && m_ready`.
  - Consequence: at most 2 words are ever owned by the block (buffered plus in flight), so no word is ever dropped.
- **Skid buffer:** 2 entries, in-order. `m_data`/`m_valid` come from the head entry. A capture and a pop in the same cycle are both honoured.
- **Output:** `m_valid` stays high and `m_data` stays stable until `m_ready`. `m_last`=1 exactly when the head word is the final word of the command (`out_left`==1).
- **Completion:** each pop decrements `out_left`. The pop with `m_last`=1 ends the command.
- **Arithmetic:** `issue_left` and `out_left` are COUNT_WIDTH unsigned, decrement only, never wrap. `occ` is a 2-bit counter. A maximum count of 2^COUNT_WIDTH−1 is supported.
- **Commands do not overlap.** `cmd_valid` is ignored while `busy`.
- **Reset mid-operation:**
  - All state clears immediately, regardless of `clk`.
  - An in-flight word is discarded and buffered words are lost.
  - The FIFO's own pointers are not touched.
  - No `done` pulse is generated.

## Timing
- **Reset values:**
  - `cmd_ready`=1.
  - `s_read_req`, `m_valid`, `m_last`, `busy` and `done` are all 0.
  - `m_data`=0.
- **Latency with an always-ready FIFO and sink:**
  - Command accepted at edge E → `s_read_req` high in cycle E+1 → first read accepted at edge E+1.
  - Word captured at edge E+2 → `m_valid` high from E+2.
- **Throughput:** 1 word/clk sustained while `s_read_ready`=`m_ready`=1.
- **Done pulse:** final pop at edge F → `done` high for cycle F+1 only, `busy` low from F+1, `cmd_ready` high from F+1. The next command can be accepted at edge F+1.
- **Zero-length command:** accepted at E → `done` high for cycle E+1; `busy` stays 0.
- **FIFO goes empty mid-transfer:** `s_read_req` drops. The stream stalls after draining the buffer and resumes one cycle after a read is accepted again.
- **`m_ready` low:** at most 2 words accumulate; then `s_read_req` stays 0 until a pop.

## Test plan
- **Basic:** FIFO preloaded with 0x11..0x14, `cmd_count`=4, `m_ready`=1. Require:
  - `m_data` sequence 0x11,0x12,0x13,0x14 on 4 consecutive cycles starting 2 cycles after command accept.
  - `m_last` only on 0x14.
  - `done` high 1 cycle after the 0x14 pop.
- **Back-pressure:** `cmd_count`=8, `m_ready` toggling 1,0,0,1. Require:
  - No loss or duplication.
  - `occ` never exceeds 2.
  - `s_read_req`=0 whenever buffered plus in-flight words equal 2.
- **Empty stall:** FIFO holds 2 words, `cmd_count`=5; write the remaining 3 words 10 cycles later. Require:
  - `s_read_req`=0 during the gap.
  - All 5 words delivered in order.
  - `busy`=1 until the final pop.
- **Zero count:** `cmd_count`=0. Require `done` pulse next cycle, no `s_read_req`, no `m_valid`.
- **Reset mid-transfer:** assert `reset` low for 1 ns mid-cycle during an 8-word command. Require:
  - All outputs at reset values immediately.
  - A new 2-word command afterwards delivers the FIFO's next 2 words correctly.
- **Back-to-back:** commands of 3 then 1 word, second command asserted at the done cycle. Require it is accepted at that edge and its first `m_valid` appears 2 cycles later.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side engine for a req/ready FIFO read port. A command asks for N words;
// the block issues read requests, absorbs the FIFO's one-cycle read latency in
// a 2-entry skid buffer and re-presents the words as a valid/ready stream with
// m_last on the final word and a one-cycle done pulse at completion.
//
// Ports:
//   clk           sole clock, rising edge
//   reset         asynchronous, active-low reset
//   cmd_valid     command request (ignored while busy)
//   cmd_ready     high only in IDLE
//   cmd_count     number of words to drain (0 is legal)
//   s_read_req    FIFO read request (combinational)
//   s_read_ready  FIFO not empty
//   s_read_data   FIFO data, valid the cycle after an accepted read
//   m_valid       output word valid
//   m_ready       downstream accepts
//   m_data        output word (head of skid buffer)
//   m_last        head word is the final word of the command
//   busy          state is not IDLE
//   done          one-cycle pulse at command completion
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fifo_stream_reader #(
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [COUNT_WIDTH-1:0] cmd_count,
    output logic                   s_read_req,
    input  logic                   s_read_ready,
    input  logic [DATA_WIDTH-1:0]  s_read_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_last,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]             r_state;
    logic [COUNT_WIDTH-1:0] r_issue_left;   // reads still to be issued
    logic [COUNT_WIDTH-1:0] r_out_left;     // words still to be popped
    logic                   r_inflight;     // read accepted last edge, data on the bus now
    logic [1:0]             r_occ;          // skid buffer occupancy 0..2
    logic [DATA_WIDTH-1:0]  r_buf0;         // head entry
    logic [DATA_WIDTH-1:0]  r_buf1;
    logic                   r_done;

    logic                   w_pop;
    logic [2:0]             w_owned;
    logic                   w_req;
    logic                   w_cmd_fire;

    assign w_pop      = (r_occ != 2'd0) && m_ready;
    assign w_cmd_fire = cmd_valid && (r_state == ST_IDLE);

    // Words the block will own after this edge, not counting a new read.
    // Keeping this below 2 before requesting means the skid buffer always has
    // room for the word that lands one cycle later.
    assign w_owned = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign w_req = (r_state == ST_READ) && (r_issue_left != CNT_ZERO)
                   && s_read_ready && (w_owned < 3'd2);

    assign s_read_req = w_req;
    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign m_valid    = (r_occ != 2'd0);
    assign m_data     = r_buf0;
    assign m_last     = m_valid && (r_out_left == CNT_ONE);
    assign done       = r_done;

    // Control: state, transfer counters, in-flight flag, done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_issue_left <= CNT_ZERO;
            r_out_left   <= CNT_ZERO;
            r_inflight   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // sees the pre-edge values regardless of statement order.
            r_done     <= 1'b0;
            r_inflight <= w_req;

            // No pop can happen in IDLE (buffer is empty), so this never
            // collides with the command latch below.
            if (w_pop) begin
                r_out_left <= r_out_left - CNT_ONE;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_fire) begin
                        r_issue_left <= cmd_count;
                        r_out_left   <= cmd_count;
                        if (cmd_count == CNT_ZERO) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (w_req) begin
                        r_issue_left <= r_issue_left - CNT_ONE;
                        if (r_issue_left == CNT_ONE) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // The last pop always happens here: it cannot precede the
                    // last read, and the last read moves us out of READ.
                    if (w_pop && (r_out_left == CNT_ONE)) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Skid buffer: the in-flight word is captured at the edge after its read,
    // and a capture and a pop in the same cycle are both honoured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the data entries are reset too; it is only two words and
            // it makes m_data a defined 0 out of reset.
            r_occ  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= s_read_data;
                    end else begin
                        r_buf1 <= s_read_data;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // A pop implies occ >= 1, so occupancy stays put.
                    if (r_occ == 2'd1) begin
                        r_buf0 <= s_read_data;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= s_read_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
//
// Directed bench for fifo_stream_reader. A small FIFO model drives the read
// port. Stimulus pushes the hand-computed expected words into a scoreboard
// queue when a command is issued; a monitor pops and compares on every
// m_valid && m_ready, and also checks the done pulse and the 2-word
// ownership limit.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_fifo_stream_reader;

    localparam int DW = 64;
    localparam int CW = 16;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_count;
    logic          s_read_req;
    logic          s_read_ready;
    logic [DW-1:0] s_read_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    fifo_stream_reader #(
        .DATA_WIDTH  (DW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_count    (cmd_count),
        .s_read_req   (s_read_req),
        .s_read_ready (s_read_ready),
        .s_read_data  (s_read_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- FIFO model (one-cycle read latency) ----------------
    logic [DW-1:0] fifo_mem [0:255];
    int            fifo_wp = 0;
    int            fifo_rp = 0;
    logic [DW-1:0] fifo_rd_data = '0;

    assign s_read_ready = (fifo_wp != fifo_rp);
    assign s_read_data  = fifo_rd_data;

    always @(posedge clk) begin
        if (s_read_req && s_read_ready) begin
            fifo_rd_data <= fifo_mem[fifo_rp[7:0]];
            fifo_rp      <= fifo_rp + 1;
        end
    end

    task automatic fifo_write(input logic [DW-1:0] d);
        fifo_mem[fifo_wp[7:0]] = d;
        fifo_wp++;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t sb[$];

    task automatic expect_word(input logic [DW-1:0] d, input logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        sb.push_back(e);
    endtask

    // ---------------- sink ready pattern ----------------
    int         ready_mode = 0;     // 0: always 1, 1: pattern 1,0,0,1, 2: always 0
    logic [3:0] bp_pat     = 4'b1001;

    initial m_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       m_ready = bp_pat[cyc[1:0]];
            2:       m_ready = 1'b0;
            default: m_ready = 1'b1;
        endcase
    end

    // ---------------- monitor ----------------
    // Sampled at negedge: a pop seen here takes effect at the next posedge.
    int   owned     = 0;   // words accepted from the FIFO and not yet popped
    logic last_pend = 1'b0;
    logic zero_pend = 1'b0;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            owned     = 0;
            last_pend = 1'b0;
            zero_pend = 1'b0;
        end else begin
            logic exp_done;
            int   pop;
            exp_t e;
            exp_done = last_pend || zero_pend;
            if (exp_done || done) begin
                check("done_pulse", done, exp_done);
                if (done) check("busy_at_done", busy, 1'b0);
            end
            pop       = (m_valid && m_ready) ? 1 : 0;
            last_pend = 1'b0;
            if (pop == 1) begin
                if (sb.size() == 0) begin
                    check("unexpected_pop", m_data, 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check("m_data", m_data, e.data);
                    check("m_last", m_last, e.last);
                    last_pend = e.last;
                end
            end
            zero_pend = cmd_valid && cmd_ready && (cmd_count == '0);
            if (busy) check("owned_le_2", (owned <= 2), 1'b1);
            if (s_read_req) check("req_with_room", ((owned - pop) < 2), 1'b1);
            owned = owned + ((s_read_req && s_read_ready) ? 1 : 0) - pop;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Call at posedge+1; returns at posedge+1 of the accepting edge, with
    // acc_edge set to the cycle number that edge starts.
    task automatic send_cmd(input int cnt, output int acc_edge);
        logic got;
        cmd_valid = 1'b1;
        cmd_count = 16'(cnt);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) got = 1'b1;
        end
        check("cmd_accepted", got, 1'b1);
        @(posedge clk); #1;
        acc_edge  = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic expect_first_valid(input string name, input int acc_edge);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (m_valid) got = 1'b1;
        end
        check({name, "_seen"}, got, 1'b1);
        check({name, "_latency"}, cyc - acc_edge, 2);
    endtask

    // Returns at posedge+1 of the cycle in which done is high.
    task automatic wait_done(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            if (done) got = 1'b1;
        end
        check({name, "_done_seen"}, got, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int a, a2, f;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_count = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #2;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_s_read_req", s_read_req, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_m_data", m_data, 64'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Basic: 4 words, always-ready sink.
        for (int i = 0; i < 4; i++) begin
            fifo_write(64'h11 + 64'(i));
            expect_word(64'h11 + 64'(i), i == 3);
        end
        send_cmd(4, a);
        expect_first_valid("basic_first", a);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("basic_consecutive_valid", m_valid, 1'b1);
        end
        wait_done("basic");
        repeat (2) @(posedge clk); #1;

        // Back-pressure: 8 words, sink ready 1,0,0,1.
        ready_mode = 1;
        for (int i = 0; i < 8; i++) begin
            fifo_write(64'hA0 + 64'(i));
            expect_word(64'hA0 + 64'(i), i == 7);
        end
        send_cmd(8, a);
        wait_done("backpressure");
        ready_mode = 0;
        repeat (2) @(posedge clk); #1;

        // Empty stall: 2 words present, 3 arrive 10 cycles later.
        fifo_write(64'h21);
        fifo_write(64'h22);
        for (int i = 0; i < 5; i++) expect_word(64'h21 + 64'(i), i == 4);
        send_cmd(5, a);
        repeat (3) @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_no_req", s_read_req, 1'b0);
            check("stall_busy", busy, 1'b1);
        end
        @(posedge clk); #1;
        for (int i = 2; i < 5; i++) fifo_write(64'h21 + 64'(i));
        wait_done("stall");
        repeat (2) @(posedge clk); #1;

        // Zero count, with the FIFO non-empty so a stray request would show.
        for (int i = 0; i < 4; i++) fifo_write(64'h51 + 64'(i));
        send_cmd(0, a);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("zero_no_req", s_read_req, 1'b0);
            check("zero_no_valid", m_valid, 1'b0);
            check("zero_not_busy", busy, 1'b0);
        end
        @(posedge clk); #1;

        // Back-to-back: 3 words then 1, second asserted in the done cycle.
        expect_word(64'h51, 1'b0);
        expect_word(64'h52, 1'b0);
        expect_word(64'h53, 1'b1);
        expect_word(64'h54, 1'b1);
        send_cmd(3, a);
        wait_done("b2b_first");
        f = cyc;
        send_cmd(1, a2);
        check("b2b_accept_edge", a2, f + 1);
        expect_first_valid("b2b_second", a2);
        wait_done("b2b_second");
        repeat (2) @(posedge clk); #1;

        // Reset mid-transfer: sink held off, so exactly 2 words leave the FIFO.
        ready_mode = 2;
        for (int i = 0; i < 10; i++) fifo_write(64'h61 + 64'(i));
        for (int i = 0; i < 8; i++) expect_word(64'h61 + 64'(i), i == 7);
        send_cmd(8, a);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #0.5;
        check("midrst_cmd_ready", cmd_ready, 1'b1);
        check("midrst_s_read_req", s_read_req, 1'b0);
        check("midrst_m_valid", m_valid, 1'b0);
        check("midrst_m_last", m_last, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_m_data", m_data, 64'h0);
        #0.5;
        reset = 1'b1;
        sb.delete();
        ready_mode = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        expect_word(64'h63, 1'b0);
        expect_word(64'h64, 1'b1);
        send_cmd(2, a);
        expect_first_valid("postrst_first", a);
        wait_done("postrst");
        repeat (3) @(posedge clk); #1;

        check("scoreboard_empty", 64'(sb.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
